keypad_scan_debounce: RTL
=========================

Name: keypad_scan_debounce

Overview:
- Parametrised keypad front end that replaces the separate synchronizer, scanner and debouncer logic.
- Drives the matrix rows active-low, one row at a time, and synchronizes the active-low column inputs.
- Debounces press and release, then emits one key code with a single-cycle valid strobe per press.
- Keeps a shift-register history of the last HIST_DEPTH codes for the seven-segment display path.

Parameters:
- NUM_ROWS, 4: number of matrix rows; range 2..8.
- NUM_COLS, 4: number of matrix columns; range 2..8.
- SCAN_CYCLES, 16: clk cycles each row is driven during scanning; must be at least 4.
- DEBOUNCE_CYCLES, 50000: consecutive stable cycles required to accept a press or a release.
- HIST_DEPTH, 2: number of code entries in the history.
- CODE_W, $clog2(NUM_ROWS*NUM_COLS): key code width (derived; do not override).

Ports:
- clk  in  1  system clock (HSOSC domain).
- reset  in  1  reset; synchronous and active-high.
- columns  in  NUM_COLS  raw column inputs, active-low, asynchronous.
- rows  out  NUM_ROWS  row drive, active-low, exactly one bit low at all times.
- key_code  out  CODE_W  code of the most recently accepted key, equal to row*NUM_COLS + col.
- key_valid  out  1  one-cycle pulse when key_code updates.
- key_held  out  1  high while an accepted key is held (HELD and DEBOUNCE_RELEASE states).
- history  out  HIST_DEPTH*CODE_W  newest code in [CODE_W-1:0]; older codes in successively higher slices.

Behaviour:
- Reset values:
  - rows = all ones except bit 0 low; row index = 0.
  - key_code = 0, key_valid = 0, key_held = 0, history = 0.
  - Both synchronizer stages set to all ones.
  - FSM in SCAN; dwell and debounce counters = 0.
- Synchronizer: two flops on columns; sync_cols lags the pins by 2 cycles. All decisions use sync_cols only.
- Press pattern: sync_cols has exactly one bit low. All ones means idle. Two or more bits low is an invalid pattern.
- SCAN:
  - The dwell counter counts 0..SCAN_CYCLES-1.
  - sync_cols is sampled only when dwell = SCAN_CYCLES-1, which masks row-switch and synchronizer settling.
  - On a valid press pattern at that sample: latch the row index and the column index of the low bit, clear the debounce counter, go to DEBOUNCE_PRESS. The row is held.
  - Otherwise rotate to the next row (NUM_ROWS-1 wraps to 0) and clear the dwell counter.
- DEBOUNCE_PRESS:
  - Each cycle that sync_cols equals the latched pattern, increment the counter.
  - When the counter reaches DEBOUNCE_CYCLES-1 on a matching cycle:
    - key_code = row*NUM_COLS + col.
    - key_valid = 1 for the next cycle only.
    - history shifts up by CODE_W and the new code enters the low slice; the oldest entry is dropped.
    - Go to HELD.
  - Any mismatch (idle, a different column, or multiple columns low) returns to SCAN at the next row with no output.
- HELD:
  - key_held = 1 and the row stays held.
  - sync_cols all ones: clear the counter and go to DEBOUNCE_RELEASE.
  - Additional presses in the same row are ignored (no rollover).
- DEBOUNCE_RELEASE:
  - Count consecutive all-ones cycles; at DEBOUNCE_CYCLES-1 go to SCAN at the next row with key_held = 0.
  - Any low column returns to HELD without emitting.
- key_valid never asserts for two consecutive cycles. Exactly one emission per press unless AUTO_REPEAT_EN is defined.
- Reset asserted in any state takes effect on the next clk edge with the reset values above. No pending emission survives reset.
- Counters saturate and never wrap. Widths are sized with $clog2 of their limit.

Optional Feature:
- Macro: KEYPAD_AUTO_REPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY (default 25000000) and REPEAT_PERIOD (default 6000000).
  - In HELD, a repeat counter starts on entry. The first re-emission of the same code (key_valid pulse and history shift) occurs after REPEAT_DELAY cycles, then every REPEAT_PERIOD cycles.
  - The repeat counter is cleared on leaving HELD, including a bounce into DEBOUNCE_RELEASE and back.
- Undefined: no repeat logic, no extra parameters; HELD never emits.

Test Plan:
All scenarios use NUM_ROWS=4, NUM_COLS=4, SCAN_CYCLES=4, DEBOUNCE_CYCLES=8, HIST_DEPTH=2.
- Reset, columns idle 4'b1111 for 40 cycles -> rows cycles 1110, 1101, 1011, 0111, each held 4 cycles; key_valid stays 0 and history = 0.
- Hold columns = 4'b1011 while rows = 4'b1011 (row 2, col 2) -> exactly one key_valid pulse; key_code = 10; history = {0, 10}; key_held = 1 until 8 idle cycles after release.
- Press row 0 col 1, release, then press row 3 col 3 -> codes 1 then 15; history = {1, 15} with 15 in the low slice.
- Column toggles every 3 cycles for 30 cycles while row 1 is active -> no key_valid; scanning resumes at row 2.
- Two columns low (4'b1001) on a row -> no emission. Reset asserted mid-DEBOUNCE_PRESS -> rows = 1110 and no pulse on the following cycle.
- With KEYPAD_AUTO_REPEAT_EN defined, REPEAT_DELAY=20, REPEAT_PERIOD=10, key held 55 cycles after acceptance -> pulses at acceptance, +20, +30, +40 and +50 cycles.

Source files
------------

// File: rtl/keypad_scan_debounce.sv
// Row-scanning keypad front end: column synchronizer, press/release debounce, code history.
// Define KEYPAD_AUTO_REPEAT_EN to re-emit a held key after REPEAT_DELAY, then every REPEAT_PERIOD.
module keypad_scan_debounce #(
  parameter int NUM_ROWS        = 4,
  parameter int NUM_COLS        = 4,
  parameter int SCAN_CYCLES     = 16,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int HIST_DEPTH      = 2,
`ifdef KEYPAD_AUTO_REPEAT_EN
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 6000000,
`endif
  parameter int CODE_W          = $clog2(NUM_ROWS*NUM_COLS)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_COLS-1:0]          columns,
  output logic [NUM_ROWS-1:0]          rows,
  output logic [CODE_W-1:0]            key_code,
  output logic                         key_valid,
  output logic                         key_held,
  output logic [HIST_DEPTH*CODE_W-1:0] history
);

  localparam int ROW_W = $clog2(NUM_ROWS);
  localparam int COL_W = $clog2(NUM_COLS);
  localparam int DW_W  = $clog2(SCAN_CYCLES);
  localparam int DB_W  = $clog2(DEBOUNCE_CYCLES);
  localparam int HW    = HIST_DEPTH*CODE_W;

  localparam logic [ROW_W-1:0]    ROW_LAST = ROW_W'(NUM_ROWS-1);
  localparam logic [ROW_W-1:0]    ROW_ONE  = 1;
  localparam logic [NUM_ROWS-1:0] ROW_BIT0 = 1;
  localparam logic [NUM_COLS-1:0] COL_ONE  = 1;
  localparam logic [DW_W-1:0]     DW_LAST  = DW_W'(SCAN_CYCLES-1);
  localparam logic [DW_W-1:0]     DW_ONE   = 1;
  localparam logic [DB_W-1:0]     DB_LAST  = DB_W'(DEBOUNCE_CYCLES-1);
  localparam logic [DB_W-1:0]     DB_ONE   = 1;

  typedef enum logic [1:0] {
    S_SCAN,
    S_DB_PRESS,
    S_HELD,
    S_DB_REL
  } state_t;

  state_t              r_state, w_state_nxt;
  logic [NUM_COLS-1:0] r_sync1, r_sync2;
  logic [NUM_COLS-1:0] r_pat, w_pat_nxt;
  logic [ROW_W-1:0]    r_row, w_row_nxt, w_row_inc;
  logic [COL_W-1:0]    r_col, w_col_nxt, w_col;
  logic [DW_W-1:0]     r_dwell, w_dwell_nxt;
  logic [DB_W-1:0]     r_db, w_db_nxt;
  logic [CODE_W-1:0]   r_code, w_code_nxt, w_code;
  logic [HW-1:0]       r_hist, w_hist_nxt;
  logic                r_valid, w_emit;
  logic [NUM_COLS-1:0] w_inv;
  logic                w_idle, w_one;

`ifdef KEYPAD_AUTO_REPEAT_EN
  localparam int RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RP_W   = $clog2(RP_MAX);
  localparam logic [RP_W-1:0] RD_LAST = RP_W'(REPEAT_DELAY-1);
  localparam logic [RP_W-1:0] RP_LAST = RP_W'(REPEAT_PERIOD-1);
  localparam logic [RP_W-1:0] RP_ONE  = 1;
  logic [RP_W-1:0] r_rep, w_rep_nxt;
  logic            r_first, w_first_nxt;
`endif

  assign w_inv     = ~r_sync2;
  assign w_idle    = &r_sync2;
  assign w_one     = (w_inv != '0) && ((w_inv & (w_inv - COL_ONE)) == '0);
  assign w_row_inc = (r_row == ROW_LAST) ? '0 : r_row + ROW_ONE;
  assign w_code    = CODE_W'(r_row) * CODE_W'(NUM_COLS) + CODE_W'(r_col);

  always_comb begin
    w_col = '0;
    for (int c = 0; c < NUM_COLS; c++)
      if (!r_sync2[c]) w_col = COL_W'(c);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pat_nxt   = r_pat;
    w_row_nxt   = r_row;
    w_col_nxt   = r_col;
    w_dwell_nxt = r_dwell;
    w_db_nxt    = r_db;
    w_code_nxt  = r_code;
    w_emit      = 1'b0;
`ifdef KEYPAD_AUTO_REPEAT_EN
    w_rep_nxt   = '0;
    w_first_nxt = 1'b1;
`endif
    unique case (r_state)
      S_SCAN: begin
        // Sample only at the end of the dwell so row switching has settled.
        if (r_dwell == DW_LAST) begin
          w_dwell_nxt = '0;
          if (w_one) begin
            w_col_nxt   = w_col;
            w_pat_nxt   = r_sync2;
            w_db_nxt    = '0;
            w_state_nxt = S_DB_PRESS;
          end else begin
            w_row_nxt = w_row_inc;
          end
        end else begin
          w_dwell_nxt = r_dwell + DW_ONE;
        end
      end
      S_DB_PRESS: begin
        if (r_sync2 == r_pat) begin
          if (r_db == DB_LAST) begin
            w_emit      = 1'b1;
            w_code_nxt  = w_code;
            w_db_nxt    = '0;
            w_state_nxt = S_HELD;
          end else begin
            w_db_nxt = r_db + DB_ONE;
          end
        end else begin
          w_row_nxt   = w_row_inc;
          w_dwell_nxt = '0;
          w_state_nxt = S_SCAN;
        end
      end
      S_HELD: begin
        if (w_idle) begin
          w_db_nxt    = '0;
          w_state_nxt = S_DB_REL;
        end
`ifdef KEYPAD_AUTO_REPEAT_EN
        else begin
          w_first_nxt = r_first;
          if (r_rep == (r_first ? RD_LAST : RP_LAST)) begin
            w_emit      = 1'b1;
            w_rep_nxt   = '0;
            w_first_nxt = 1'b0;
          end else begin
            w_rep_nxt = r_rep + RP_ONE;
          end
        end
`endif
      end
      S_DB_REL: begin
        if (!w_idle) begin
          w_state_nxt = S_HELD;
        end else if (r_db == DB_LAST) begin
          w_row_nxt   = w_row_inc;
          w_dwell_nxt = '0;
          w_state_nxt = S_SCAN;
        end else begin
          w_db_nxt = r_db + DB_ONE;
        end
      end
      default: w_state_nxt = S_SCAN;
    endcase
    w_hist_nxt = w_emit ? ((r_hist << CODE_W) | HW'(w_code_nxt)) : r_hist;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_SCAN;
      r_sync1 <= '1;
      r_sync2 <= '1;
      r_pat   <= '1;
      r_row   <= '0;
      r_col   <= '0;
      r_dwell <= '0;
      r_db    <= '0;
      r_code  <= '0;
      r_hist  <= '0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sync1 <= columns;
      r_sync2 <= r_sync1;
      r_pat   <= w_pat_nxt;
      r_row   <= w_row_nxt;
      r_col   <= w_col_nxt;
      r_dwell <= w_dwell_nxt;
      r_db    <= w_db_nxt;
      r_code  <= w_code_nxt;
      r_hist  <= w_hist_nxt;
      r_valid <= w_emit;
    end
  end

`ifdef KEYPAD_AUTO_REPEAT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rep   <= '0;
      r_first <= 1'b1;
    end else begin
      r_rep   <= w_rep_nxt;
      r_first <= w_first_nxt;
    end
  end
`endif

  assign rows      = ~(ROW_BIT0 << r_row);
  assign key_code  = r_code;
  assign key_valid = r_valid;
  assign key_held  = (r_state == S_HELD) || (r_state == S_DB_REL);
  assign history   = r_hist;

endmodule
